// File: rtl/ram_dp_if.sv
// Bus bundle for ram_dp: port A read/write, port B read-only, and the busy flag.
interface ram_dp_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
);
    logic              load;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] d;
    logic [DWIDTH-1:0] q;
    logic [AWIDTH-1:0] raddr;
    logic [DWIDTH-1:0] rq;
    logic              busy;

    modport master (output load, addr, d, raddr, input q, rq, busy);
    modport slave  (input load, addr, d, raddr, output q, rq, busy);
endinterface

// File: rtl/ram_dp.sv
// Dual-port RAM (A: read/write write-first, B: read-only read-first) with a clear sequencer after reset.
// Optional macro RAM_DP_OUTREG_EN adds a second output register stage on q and rq.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | zeroing mem[cnt] each cycle, busy=1, all accesses ignored
// READY | normal operation, busy=0
module ram_dp #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int WORDS  = 2**AWIDTH
) (
    input  logic     clk,
    input  logic     rst,
    ram_dp_if.slave  bus
);
    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DWIDTH-1:0] qa_q, qa_d;
    logic [DWIDTH-1:0] rqa_q, rqa_d;

    logic              we;
    logic [AWIDTH-1:0] wa;
    logic [DWIDTH-1:0] wd;

    logic [DWIDTH-1:0] mem [WORDS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        qa_d    = '0;
        rqa_d   = '0;
        we      = 1'b0;
        wa      = bus.addr;
        wd      = bus.d;
        case (state_q)
            CLEAR: begin
                we     = 1'b1;
                wa     = cnt_q;
                wd     = '0;
                cnt_d  = cnt_q + AWIDTH'(1);
                busy_d = 1'b1;
                if (cnt_q == AWIDTH'(WORDS - 1)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                we     = bus.load;
                busy_d = 1'b0;
                // Port B reads the pre-write contents, giving read-first on collision.
                qa_d   = bus.load ? bus.d : mem[bus.addr];
                rqa_d  = mem[bus.raddr];
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            qa_q    <= '0;
            rqa_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            qa_q    <= qa_d;
            rqa_q   <= rqa_d;
        end
    end

    // No reset on the array itself; contents come only from the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[wa] <= wd;
        end
    end

`ifdef RAM_DP_OUTREG_EN
    logic [DWIDTH-1:0] qo_q, qo_d;
    logic [DWIDTH-1:0] rqo_q, rqo_d;

    always_comb begin
        qo_d  = (state_q == CLEAR) ? '0 : qa_q;
        rqo_d = (state_q == CLEAR) ? '0 : rqa_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qo_q  <= '0;
            rqo_q <= '0;
        end else begin
            qo_q  <= qo_d;
            rqo_q <= rqo_d;
        end
    end

    assign bus.q  = qo_q;
    assign bus.rq = rqo_q;
`else
    assign bus.q  = qa_q;
    assign bus.rq = rqa_q;
`endif

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_ram_dp.sv
// Directed self-checking bench for ram_dp at AWIDTH=4 (16 words), DWIDTH=16.
module tb_ram_dp;
    localparam int DW = 16;
    localparam int AW = 4;
`ifdef RAM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ram_dp_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    ram_dp #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
        bus.load = 1'b1;
        bus.addr = a;
        bus.d    = v;
        step();
        bus.load = 1'b0;
        bus.d    = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] ra,
                      output logic [DW-1:0] oq, output logic [DW-1:0] orq);
        bus.load  = 1'b0;
        bus.addr  = a;
        bus.raddr = ra;
        repeat (LAT) step();
        oq  = bus.q;
        orq = bus.rq;
    endtask

    // Waits out the clear, checking q/rq stay 0; returns the number of busy cycles seen.
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n_checks++;
            if (bus.q !== '0 || bus.rq !== '0) begin
                n_fail++;
                $display("FAIL %s_out_zero: q=%h rq=%h required 0", tag, bus.q, bus.rq);
            end
            n++;
            step();
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles", tag, bus.busy, n);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [DW-1:0] vq, vrq;
        pulse_reset();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.q !== '0 || bus.rq !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b q=%h rq=%h required busy=1 q=0 rq=0",
                     bus.busy, bus.q, bus.rq);
        end
        wait_ready("reset", n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles required 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            rd(AW'(i), AW'(15 - i), vq, vrq);
            n_checks++;
            if (vq !== '0 || vrq !== '0) begin
                n_fail++;
                $display("FAIL clear_read[%0d]: q=%h rq=%h required 0", i, vq, vrq);
            end
        end
    endtask

    task automatic test_write_read();
        bus.raddr = 4'd3;
        bus.load  = 1'b1;
        bus.addr  = 4'd3;
        bus.d     = 16'h1234;
        step();
        bus.load = 1'b0;
        bus.d    = '0;
        repeat (LAT - 1) step();
        n_checks++;
        if (bus.q !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_first_q: got %h required 1234", bus.q);
        end
        step();
        n_checks++;
        if (bus.q !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_back_q: got %h required 1234", bus.q);
        end
        step();
        n_checks++;
        if (bus.rq !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_back_rq: got %h required 1234", bus.rq);
        end
    endtask

    task automatic test_x_data();
        logic [DW-1:0] vq, vrq;
        bus.d = 'x;
        rd(4'd3, 4'd3, vq, vrq);
        bus.d = '0;
        n_checks++;
        if (vq !== 16'h1234 || vrq !== 16'h1234) begin
            n_fail++;
            $display("FAIL x_on_d: q=%h rq=%h required 1234/1234", vq, vrq);
        end
    endtask

    task automatic test_collision();
        wr(4'd5, 16'hAAAA);
        bus.raddr = 4'd5;
        bus.load  = 1'b1;
        bus.addr  = 4'd5;
        bus.d     = 16'h5555;
        step();
        bus.load = 1'b0;
        bus.d    = '0;
        repeat (LAT - 1) step();
        n_checks++;
        if (bus.rq !== 16'hAAAA || bus.q !== 16'h5555) begin
            n_fail++;
            $display("FAIL collision: rq=%h q=%h required rq=aaaa q=5555", bus.rq, bus.q);
        end
        step();
        n_checks++;
        if (bus.rq !== 16'h5555) begin
            n_fail++;
            $display("FAIL collision_next: rq=%h required 5555", bus.rq);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vq, vrq;
        bus.load = 1'b1;
        bus.addr = 4'd9;
        bus.d    = 16'h0011;
        step();
        bus.d    = 16'h0022;
        step();
        bus.d    = 16'h0033;
        step();
        bus.load = 1'b0;
        bus.d    = '0;
        rd(4'd9, 4'd9, vq, vrq);
        n_checks++;
        if (vq !== 16'h0033 || vrq !== 16'h0033) begin
            n_fail++;
            $display("FAIL back_to_back: q=%h rq=%h required 0033", vq, vrq);
        end
    endtask

    task automatic test_last_addr();
        logic [DW-1:0] vq, vrq;
        wr(4'd15, 16'hFFFF);
        wr(4'd0, 16'h0001);
        rd(4'd15, 4'd0, vq, vrq);
        n_checks++;
        if (vq !== 16'hFFFF || vrq !== 16'h0001) begin
            n_fail++;
            $display("FAIL last_addr_a: q=%h rq=%h required ffff/0001", vq, vrq);
        end
        rd(4'd0, 4'd15, vq, vrq);
        n_checks++;
        if (vq !== 16'h0001 || vrq !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL last_addr_b: q=%h rq=%h required 0001/ffff", vq, vrq);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [DW-1:0] vq, vrq;
        wr(4'd7, 16'h00FF);
        rd(4'd7, 4'd7, vq, vrq);
        n_checks++;
        if (vq !== 16'h00FF) begin
            n_fail++;
            $display("FAIL mid_prewrite: q=%h required 00ff", vq);
        end
        // A write coinciding with reset must be dropped.
        bus.load = 1'b1;
        bus.addr = 4'd8;
        bus.d    = 16'h1111;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        bus.load = 1'b0;
        bus.d    = '0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.q !== '0 || bus.rq !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b q=%h rq=%h required 1/0/0",
                     bus.busy, bus.q, bus.rq);
        end
        wait_ready("mid", n);
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL mid_busy_len: got %0d required 16", n);
        end
        rd(4'd7, 4'd8, vq, vrq);
        n_checks++;
        if (vq !== '0 || vrq !== '0) begin
            n_fail++;
            $display("FAIL mid_cleared: q=%h rq=%h required 0", vq, vrq);
        end
    endtask

    task automatic test_busy_access();
        int n;
        logic [DW-1:0] vq, vrq;
        pulse_reset();
        repeat (4) step();
        bus.load  = 1'b1;
        bus.addr  = 4'd2;
        bus.raddr = 4'd2;
        bus.d     = 16'hBEEF;
        step();
        bus.load = 1'b0;
        bus.d    = '0;
        wait_ready("busy_acc", n);
        n_checks++;
        if (n !== 11) begin
            n_fail++;
            $display("FAIL busy_acc_len: remaining busy %0d required 11", n);
        end
        rd(4'd2, 4'd2, vq, vrq);
        n_checks++;
        if (vq !== '0 || vrq !== '0) begin
            n_fail++;
            $display("FAIL busy_acc_ignored: q=%h rq=%h required 0", vq, vrq);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.addr  = '0;
        bus.raddr = '0;
        bus.d     = '0;
        repeat (2) step();
        test_reset();
        test_write_read();
        test_x_data();
        test_collision();
        test_back_to_back();
        test_last_addr();
        test_reset_mid();
        test_busy_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL provide parameter DWIDTH, default 16, data word width in bits.
REQ-002 SHALL provide parameter AWIDTH, default 12, address width in bits.
REQ-003 SHALL provide parameter WORDS, default 4096, number of words, always equal to 2**AWIDTH.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  input  1  port A write enable.
REQ-007 SHALL have port addr  input  AWIDTH  port A read/write address.
REQ-008 SHALL have port d  input  DWIDTH  port A write data.
REQ-009 SHALL have port q  output  DWIDTH  port A registered read data.
REQ-010 SHALL have port raddr  input  AWIDTH  port B read-only address.
REQ-011 SHALL have port rq  output  DWIDTH  port B registered read data.
REQ-012 SHALL have port busy  output  1  high while the clear sequencer runs; port A and port B accesses are ignored while it is high.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and READY.
REQ-014 SHALL, in CLEAR, write 0 to mem[cnt] every cycle, where cnt is an AWIDTH-bit counter, increment cnt, and go to READY after the cycle that writes mem[WORDS-1].
REQ-015 SHALL drive busy=1 in CLEAR and busy=0 in READY, so busy is high for exactly WORDS cycles after the first cycle with rst low.
REQ-016 SHALL, in CLEAR, ignore load, addr, d and raddr, and hold q and rq at 0.
REQ-017 SHALL, in READY with load=1, write d to mem[addr] and load q with d one cycle later (write-first).
REQ-018 SHALL, in READY with load=0, load q with mem[addr] one cycle later.
REQ-019 SHALL, in READY, load rq with mem[raddr] one cycle later.
REQ-020 SHALL, when load=1 and raddr==addr in the same cycle, load rq with the data held before the write (read-first on port B).
REQ-021 SHALL give back-to-back writes to the same address last-writer-wins, one write per cycle, with no stall.
REQ-022 SHALL leave q and rq unaffected by any X on d when load=0.

Reset
REQ-023 SHALL, on any clock edge with rst=1, set the state to CLEAR, cnt=0, q=0, rq=0 and busy=1.
REQ-024 SHALL restart the clear sequence from address 0 when rst is asserted during CLEAR or READY, discarding any write in that cycle.
REQ-025 SHALL have memory contents after reset defined only by the clear sequence, with no initial block required.

Configuration
REQ-026 SHALL, with macro RAM_DP_OUTREG_EN defined, add one extra output register stage to q and rq, giving 2-cycle read latency; the extra registers reset to 0 and pass only 0 while busy.
REQ-027 SHALL, without RAM_DP_OUTREG_EN, have 1-cycle read latency on q and rq, and behave identically in all other respects.

Verification
REQ-028 SHALL cover clear after reset: AWIDTH=4 (WORDS=16), pulse rst for 1 cycle -> busy high for exactly 16 cycles, then reads of addresses 0..15 on both ports return 0.
REQ-029 SHALL cover write then read: READY, load=1 addr=3 d=16'h1234, next cycle load=0 addr=3 -> q=16'h1234 after the write cycle and after the read cycle (1-cycle latency; 2 cycles with RAM_DP_OUTREG_EN).
REQ-030 SHALL cover collision: mem[5]=16'hAAAA, load=1 addr=5 d=16'h5555 with raddr=5 -> rq=16'hAAAA and q=16'h5555; the next cycle with raddr=5 gives rq=16'h5555.
REQ-031 SHALL cover access during busy: load=1 addr=2 d=16'hBEEF issued at clear cycle 4 -> ignored; after busy falls, mem[2] reads 0 and q stayed 0 throughout.
REQ-032 SHALL cover reset mid-operation: write mem[7]=16'h00FF, assert rst -> busy rises, q=0 and rq=0, and after the clear completes mem[7] reads 0.
REQ-033 SHALL cover the last address: write mem[15]=16'hFFFF and mem[0]=16'h0001 -> reading 15 then 0 returns 16'hFFFF then 16'h0001, with no aliasing.
